cpu_output_buffer: RTL and testbench

- Downstream consumer of the CPU output port: captures each `data_out` word the core emits under `output_en`.
- Buffers captured words in a FIFO and streams them out as bytes over a ready/valid handshake, least-significant byte first.
- Decouples the multicycle core from a slow byte sink (UART TX, debug host).
- Never stalls the core. Words arriving while the FIFO is full are dropped and flagged.

---
 rtl/riscv_pkg.sv | 5 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/cpu_output_buffer.sv | 77 +++++++
 tb/tb_cpu_output_buffer.sv | 111 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: core-wide data sizes shared by blocks attached to the CPU.
package riscv_pkg;
    localparam int WORD_SIZE = 32;
    localparam int BYTE_W    = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read and registered full flag.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count_next;
    logic             do_push, do_pop;

    assign empty      = count == '0;
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rdata      = mem[rd_ptr];
    assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

    // pointers and occupancy; full is registered so a same-cycle pop never admits a push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= count_next == (AW+1)'(DEPTH);
        end
    end

    // storage needs no reset; only slots behind the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/cpu_output_buffer.sv
// cpu_output_buffer: buffers CPU output words and streams them LSB-first as bytes.
module cpu_output_buffer #(
    parameter int WORD_SIZE = riscv_pkg::WORD_SIZE,
    parameter int DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   output_en,
    input  logic [WORD_SIZE-1:0]   data_out,
    output logic                   full,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic [7:0]             byte_data,
    output logic                   last_byte
);
    import riscv_pkg::*;

    localparam int BYTES = WORD_SIZE / BYTE_W;
    localparam int IW    = BYTES > 1 ? $clog2(BYTES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] shift, head;
    logic [IW-1:0]        idx;
    logic                 empty, hs, at_last, pop;

    assign hs        = byte_valid && byte_ready;
    assign at_last   = idx == IW'(BYTES-1);
    assign pop       = !empty && (state == IDLE || (hs && at_last));
    assign byte_data = shift[BYTE_W-1:0];

    sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (output_en),
        .pop   (pop),
        .wdata (data_out),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // serializer: load head when idle or on the final byte handshake, else shift per accepted byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift      <= '0;
            idx        <= '0;
            byte_valid <= 1'b0;
            last_byte  <= 1'b0;
        end else if (pop) begin
            state      <= SEND;
            shift      <= head;
            idx        <= '0;
            byte_valid <= 1'b1;
            last_byte  <= BYTES == 1;
        end else if (hs && at_last) begin
            state      <= IDLE;
            byte_valid <= 1'b0;
            last_byte  <= 1'b0;
        end else if (hs) begin
            shift     <= shift >> BYTE_W;
            idx       <= idx + 1'b1;
            last_byte <= (idx + 1'b1) == IW'(BYTES-1);
        end
    end

    // sticky drop flag for words that arrive while the FIFO is full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow <= 1'b0;
        else if (output_en && full) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_cpu_output_buffer.sv
// tb_cpu_output_buffer: scoreboard bench with a word-level reference model.
module tb_cpu_output_buffer;
    logic        clk = 0, rst = 0, output_en = 0, byte_ready = 0;
    logic [31:0] data_out = 0;
    logic        full, overflow, byte_valid, last_byte;
    logic [3:0]  count;
    logic [7:0]  byte_data;

    int compared = 0, mismatched = 0;
    int mc = 0, mr = 0;
    bit movf = 0;
    logic [8:0] expq[$];

    cpu_output_buffer #(.WORD_SIZE(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .output_en(output_en), .data_out(data_out),
        .full(full), .overflow(overflow), .count(count), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_data(byte_data), .last_byte(last_byte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: drive inputs, then advance the model (words in FIFO, bytes left in serializer)
    task automatic step(input bit en, input logic [31:0] d, input bit rdy);
        bit hs, acc, pop;
        output_en  = en;
        data_out   = d;
        byte_ready = rdy;
        @(posedge clk);
        if (rst) begin
            hs  = mr > 0 && rdy;
            acc = en && mc < 8;
            pop = mc > 0 && (mr == 0 || (hs && mr == 1));
            if (en && mc == 8) movf = 1;
            if (acc) for (int i = 0; i < 4; i++) expq.push_back({i == 3, d[8*i +: 8]});
            mr = pop ? 4 : (hs ? mr - 1 : mr);
            mc = mc + int'(acc) - int'(pop);
        end
        #1;
    endtask

    // monitor: status against the model every cycle, bytes against the scoreboard on handshake
    always @(negedge clk) begin
        if (rst) begin
            chk("count", count, mc);
            chk("full", full, mc == 8);
            chk("overflow", overflow, movf);
            chk("byte_valid", byte_valid, mr > 0);
            if (byte_valid && byte_ready) begin
                if (expq.size() == 0) chk("unexpected_byte", byte_data, -1);
                else begin
                    chk("byte_data", byte_data, expq[0][7:0]);
                    chk("last_byte", last_byte, expq[0][8]);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        #2;
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_last_byte", last_byte, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        step(1, 32'hDEADBEEF, 1);
        repeat (6) step(0, 0, 1);
        step(1, 32'hDEADBEEF, 0);
        repeat (3) step(0, 0, 1);
        repeat (4) step(0, 0, 0);
        repeat (6) step(0, 0, 1);
        step(1, 32'h03020100, 1);
        step(1, 32'h07060504, 1);
        repeat (10) step(0, 0, 1);
        for (int w = 0; w < 10; w++) step(1, w, 0);
        repeat (3) step(0, 0, 0);
        repeat (45) step(0, 0, 1);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 99) < 55);
        for (int w = 0; w < 3; w++) step(1, 32'hA0B0C0D0 + w, 1);
        step(0, 0, 1);
        #2 rst = 0;
        #1;
        chk("arst_byte_valid", byte_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_full", full, 0);
        chk("arst_overflow", overflow, 0);
        mc = 0; mr = 0; movf = 0;
        expq.delete();
        repeat (2) step(0, 0, 1);
        rst = 1;
        repeat (5) step(0, 0, 1);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) < 30, $urandom, $urandom_range(0, 99) < 70);
        repeat (60) step(0, 0, 1);
        chk("drain_empty", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
